// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB types, response codes and lane helper
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam logic APB_OKAY   = 1'b0;
  localparam logic APB_SLVERR = 1'b1;

  // Number of byte-offset address bits below the word index.
  function automatic int lsb_of(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// rtl/apb_mem_array.sv - register array with async clear, one write port, one combinational read port
module apb_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int IW         = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [IW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [IW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer with word-addressed register memory and wait states
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWRDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int LSB = lsb_of(DATA_WIDTH);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << LSB) - 64'd1);
  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES);

  apb_state_e            r_state;
  apb_state_e            w_next;
  logic [3:0]            r_cnt;
  logic [IW-1:0]         r_idx;
  logic                  r_write;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_prdata;

  logic [ADDR_WIDTH-1:0] w_word;
  logic [IW-1:0]         w_idx;
  logic                  w_err;
  logic                  w_setup;
  logic                  w_ready;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_word  = PADDR >> LSB;
  assign w_idx   = w_word[IW-1:0];
  assign w_err   = (|(PADDR & ALIGN_MASK)) || (w_word >= ADDR_WIDTH'(DEPTH));
  assign w_setup = (r_state == IDLE) && PSEL && !PENABLE;

  apb_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IW        (IW)
  ) u_mem (
    .i_clk  (PCLK),
    .i_rst  (PRESET),
    .i_we   (w_we),
    .i_waddr(r_idx),
    .i_wdata(r_wdata),
    .i_raddr(w_idx),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_we    = 1'b0;
    case (r_state)
      IDLE: begin
        if (PSEL && !PENABLE) w_next = ACCESS;
      end
      ACCESS: begin
        w_ready = (r_cnt == CNT_LAST);
        if (!PSEL) begin
          w_next = IDLE;
        end else if (w_ready && PENABLE) begin
          w_next = IDLE;
          w_we   = r_write && !r_err;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Address, data and error are frozen at setup; later bus changes are ignored.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_wdata  <= '0;
      r_prdata <= '0;
    end else if (w_setup) begin
      r_cnt   <= '0;
      r_idx   <= w_idx;
      r_write <= PWRITE;
      r_err   <= w_err;
      r_wdata <= PWRDATA;
      if (!PWRITE) r_prdata <= w_err ? '0 : w_rdata;
    end else if ((r_state == ACCESS) && PSEL && !w_ready) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign PREADY  = w_ready;
  assign PSLVERR = (w_ready && r_err) ? APB_SLVERR : APB_OKAY;
  assign PRDATA  = r_prdata;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - scoreboard bench for apb_slave_mem at zero and three wait states
module tb_apb_slave_mem;

  localparam int DW = 32;
  localparam int AW = 32;

  logic clk    = 1'b0;
  logic clk_en = 1'b1;
  logic rst    = 1'b1;
  int   cyc    = 0;
  int   tests  = 0;
  int   fails  = 0;

  logic          psel    [2];
  logic          penable [2];
  logic          pwrite  [2];
  logic [AW-1:0] paddr   [2];
  logic [DW-1:0] pwdata  [2];

  logic [DW-1:0] prdata0, prdata1;
  logic          pready0, pready1, pslverr0, pslverr1;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    logic        err;
    int          at;
  } exp_t;

  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [31:0] mdl [2][16];

  apb_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(16), .WAIT_CYCLES(0)) u_dut0 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable[0]), .PADDR(paddr[0]),
    .PWRITE(pwrite[0]), .PWRDATA(pwdata[0]), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
  );

  apb_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(16), .WAIT_CYCLES(3)) u_dut1 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable[1]), .PADDR(paddr[1]),
    .PWRITE(pwrite[1]), .PWRDATA(pwdata[1]), .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic rdy_of(input int d);
    return (d == 0) ? pready0 : pready1;
  endfunction

  always @(negedge clk) begin
    logic        rdy, err, sel;
    logic [31:0] dat;
    exp_t        e;
    for (int d = 0; d < 2; d++) begin
      rdy = (d == 0) ? pready0 : pready1;
      err = (d == 0) ? pslverr0 : pslverr1;
      dat = (d == 0) ? prdata0 : prdata1;
      sel = psel[d];
      if (rdy) begin
        if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
          chk($sformatf("unexpected_pready%0d", d), 32'(rdy), 32'd0);
        end else begin
          e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
          chk($sformatf("latency%0d", d), 32'(cyc), 32'(e.at));
          chk($sformatf("pslverr%0d", d), 32'(err), 32'(e.err));
          if (e.rd) chk($sformatf("prdata%0d", d), dat, e.data);
        end
      end else if (sel) begin
        chk($sformatf("pslverr_without_pready%0d", d), 32'(err), 32'd0);
      end
    end
  end

  task automatic setup(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
  endtask

  task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    logic err;
    int   idx;
    bit   done;
    err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd16);
    idx = int'(addr[5:2]);
    setup(d, wr, addr, data);
    e.rd   = !wr;
    e.err  = err;
    e.data = (wr || err) ? 32'd0 : mdl[d][idx];
    e.at   = cyc + 1 + ((d == 0) ? 0 : 3);
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    @(posedge clk); #1;
    penable[d] = 1'b1;
    paddr[d]   = $urandom;
    pwdata[d]  = $urandom;
    done = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (rdy_of(d)) done = 1;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL timeout%0d: no PREADY, expected within 20 cycles", d);
    end
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
    if (wr && !err) mdl[d][idx] = data;
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) mdl[d][i] = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          r;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 0; penable[d] = 0; pwrite[d] = 0; paddr[d] = 0; pwdata[d] = 0;
    end
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pready0", 32'(pready0), 32'd0);
    chk("rst_prdata1", prdata1, 32'd0);

    xfer(0, 1'b1, 32'h08, 32'hDEADBEEF);
    xfer(0, 1'b0, 32'h08, 32'h0);
    xfer(0, 1'b1, 32'h0C, 32'h11112222);
    xfer(0, 1'b0, 32'h0C, 32'h0);

    @(negedge clk); #1 clk_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pready", 32'(pready0), 32'd0);
    chk("async_rst_pslverr", 32'(pslverr0), 32'd0);
    chk("async_rst_prdata", prdata0, 32'd0);
    #3 rst = 1'b0;
    clear_model();
    clk_en = 1'b1;
    xfer(0, 1'b0, 32'h0C, 32'h0);

    xfer(1, 1'b0, 32'h00, 32'h0);

    xfer(0, 1'b1, 32'h00, 32'hCAFE0000);
    xfer(0, 1'b1, 32'h3C, 32'h0000F00D);
    xfer(0, 1'b1, 32'h40, 32'h12345678);
    xfer(0, 1'b0, 32'h00, 32'h0);
    xfer(0, 1'b0, 32'h3C, 32'h0);
    xfer(0, 1'b0, 32'h06, 32'h0);

    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b1; paddr[0] = 32'h00; pwrite[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 psel[0] = 1'b0; penable[0] = 1'b0;
    xfer(0, 1'b0, 32'h00, 32'h0);

    xfer(1, 1'b1, 32'h04, 32'h11223344);
    setup(1, 1'b1, 32'h04, 32'hA5A5A5A5);
    @(posedge clk); #1 penable[1] = 1'b1;
    @(posedge clk); #1 psel[1] = 1'b0; penable[1] = 1'b0;
    repeat (4) @(posedge clk);
    xfer(1, 1'b0, 32'h04, 32'h0);

    xfer(0, 1'b1, 32'h10, 32'h0BADF00D);
    setup(1, 1'b1, 32'h08, 32'h77777777);
    @(posedge clk); #1 penable[1] = 1'b1;
    @(posedge clk); #2 rst = 1'b1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    clear_model();
    for (int i = 0; i < 16; i++) xfer(1, 1'b0, 32'(i * 4), 32'h0);
    xfer(0, 1'b0, 32'h10, 32'h0);

    for (int n = 0; n < 120; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = 32'($urandom_range(0, 15)) << 2;
      else if (r == 7) a = (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'($urandom_range(16, 63)) << 2;
      else             a = $urandom;
      xfer(n % 2, 1'($urandom_range(0, 1)), a, $urandom);
    end

    repeat (5) @(posedge clk);
    chk("sb0_drained", 32'(sb0.size()), 32'd0);
    chk("sb1_drained", 32'(sb1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
